// File: rtl/fpa_mpadd_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package fpa_mpadd_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mpadd_state_t;

    // Word index width; never narrower than one bit so WORDS=1 still has a register.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/fpa_mpadd_sequencer_csa.sv
// N-bit carry-skip adder used by the multi-precision sequencer.
// MODEL "Behavioral" uses a plain adder; any other value builds explicit 4-bit skip blocks.
module CarrySkipAdd #(
    parameter int unsigned N     = 32,
    parameter string       MODEL = "Behavioral"
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    localparam int unsigned BLK = 4;

    if (MODEL == "Behavioral") begin : g_beh
        assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    end else begin : g_skip
        logic [N:0] c;
        logic       blk_cin;
        logic       blk_p;

        always_comb begin
            c       = '0;
            s       = '0;
            c[0]    = ci;
            blk_cin = ci;
            blk_p   = 1'b1;
            for (int unsigned i = 0; i < N; i++) begin
                s[i]   = a[i] ^ b[i] ^ c[i];
                c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
                blk_p  = blk_p & (a[i] ^ b[i]);
                // A fully propagating block forwards its carry-in straight to its carry-out.
                if (((i % BLK) == BLK - 1) || (i == N - 1)) begin
                    if (blk_p) begin
                        c[i+1] = blk_cin;
                    end
                    blk_cin = c[i+1];
                    blk_p   = 1'b1;
                end
            end
        end

        assign co = c[N];
    end

endmodule

// File: rtl/fpa_mpadd_sequencer.sv
// WORDS x N-bit add/subtract built by stepping one N-bit CarrySkipAdd over the words.
// Optional feature macro: FPA_MPADD_SUB_EN (honour in_sub as A - B).
module fpa_mpadd_sequencer
    import fpa_mpadd_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned WORDS = 4,
    parameter string       MODEL = "Behavioral"
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORDS*N-1:0] in_a,
    input  logic [WORDS*N-1:0] in_b,
    input  logic               in_ci,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORDS*N-1:0] out_c,
    output logic               out_co,
    output logic               out_ovf
);

    localparam int unsigned   W    = WORDS * N;
    localparam int unsigned   IW   = idx_width(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    mpadd_state_t            state_q, state_d;
    logic [WORDS-1:0][N-1:0] a_q, b_q, c_q;
    logic [IW-1:0]           idx_q;
    logic                    carry_q;
    logic                    ovf_q;

    logic [W-1:0] beff;
    logic         ci_eff;
    logic [N-1:0] a_word, b_word, sum_word;
    logic         co_word;

`ifdef FPA_MPADD_SUB_EN
    assign beff   = in_sub ? ~in_b : in_b;
    assign ci_eff = in_sub ? 1'b1 : in_ci;
`else
    logic unused_sub;
    assign unused_sub = in_sub;
    assign beff       = in_b;
    assign ci_eff     = in_ci;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
                a_word = a_q[i];
                b_word = b_q[i];
            end
        end
    end

    CarrySkipAdd #(
        .N     (N),
        .MODEL (MODEL)
    ) u_csa (
        .a  (a_word),
        .b  (b_word),
        .ci (carry_q),
        .s  (sum_word),
        .co (co_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            a_q     <= in_a;
            b_q     <= beff;
            carry_q <= ci_eff;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                if (idx_q == IW'(i)) begin
                    c_q[i] <= sum_word;
                end
            end
            carry_q <= co_word;
            if (idx_q == LAST) begin
                idx_q <= '0;
                // Sign bits of the top word decide two's-complement overflow.
                ovf_q <= (a_word[N-1] == b_word[N-1]) && (sum_word[N-1] != a_word[N-1]);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign out_c   = c_q;
    assign out_co  = carry_q;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_fpa_mpadd_sequencer.sv
// Directed bench for fpa_mpadd_sequencer: a 4x32 instance for the vector table and
// handshake corners, plus a 1x8 instance for the single-word timing cases.
module tb_fpa_mpadd_sequencer;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         ci;
        logic         sub;
        logic [127:0] c;
        logic         co;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, in_ready, in_ci = 1'b0, in_sub = 1'b0;
    logic [127:0] in_a = '0, in_b = '0, out_c;
    logic         out_valid, out_ready = 1'b0, out_co, out_ovf;

    logic         in_valid1 = 1'b0, in_ready1, in_ci1 = 1'b0, in_sub1 = 1'b0;
    logic [7:0]   in_a1 = '0, in_b1 = '0, out_c1;
    logic         out_valid1, out_ready1 = 1'b0, out_co1, out_ovf1;

    fpa_mpadd_sequencer #(.N(32), .WORDS(4), .MODEL("Behavioral")) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_co    (out_co),
        .out_ovf   (out_ovf)
    );

    fpa_mpadd_sequencer #(.N(8), .WORDS(1), .MODEL("Skip")) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .in_ci     (in_ci1),
        .in_sub    (in_sub1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_c     (out_c1),
        .out_co    (out_co1),
        .out_ovf   (out_ovf1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [127:0] a, input logic [127:0] b, input logic ci,
                                input logic sub, input logic [127:0] c, input logic co,
                                input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.ci = ci; v.sub = sub; v.c = c; v.co = co; v.ovf = ovf;
        return v;
    endfunction

    // Drive one request into dut4 and wait (bounded) for out_valid; lat counts edges from accept.
    task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic ci,
                          input logic sub, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        #1 in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_op(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({name, "_in_ready_after"}, 128'(in_ready), 128'd1);
        chk({name, "_valid_drop"}, 128'(out_valid), 128'd0);
    endtask

    vec_t vecs[$];
    int   lat;
    logic [127:0] held_c;
    logic held_co;
    int   acc[$];

    initial begin
        vecs.push_back(mk({128{1'b1}}, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1, 1'b0));
        vecs.push_back(mk({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0,
                          {1'b1, 127'd0}, 1'b0, 1'b1));
        vecs.push_back(mk(128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0, 1'b0));
        vecs.push_back(mk({64'd0, {64{1'b1}}}, 128'd1, 1'b0, 1'b0,
                          {63'd0, 1'b1, 64'd0}, 1'b0, 1'b0));
        vecs.push_back(mk({1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0, 1'b0, 128'd0, 1'b1, 1'b1));
        vecs.push_back(mk(128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
                          128'h11111111_11111111_11111111_11111111, 1'b1, 1'b0,
                          128'h23456789_ABCDF001_20FEDCBA_98765433, 1'b0, 1'b0));
`ifdef FPA_MPADD_SUB_EN
        vecs.push_back(mk(128'd0, 128'd1, 1'b0, 1'b1, {128{1'b1}}, 1'b0, 1'b0));
        vecs.push_back(mk(128'd5, 128'd5, 1'b0, 1'b1, 128'd0, 1'b1, 1'b0));
        vecs.push_back(mk({1'b1, 127'd0}, 128'd1, 1'b0, 1'b1,
                          {1'b0, {127{1'b1}}}, 1'b1, 1'b1));
`else
        vecs.push_back(mk(128'd5, 128'd5, 1'b0, 1'b1, 128'd10, 1'b0, 1'b0));
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_c", out_c, 128'd0);
        chk("rst_out_co", 128'(out_co), 128'd0);
        chk("rst_out_ovf", 128'(out_ovf), 128'd0);
        chk("rst_out_valid1", 128'(out_valid1), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_in_ready1", 128'(in_ready1), 128'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, lat);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd5);
            chk($sformatf("vec%0d_c", i), out_c, vecs[i].c);
            chk($sformatf("vec%0d_co", i), 128'(out_co), 128'(vecs[i].co));
            chk($sformatf("vec%0d_ovf", i), 128'(out_ovf), 128'(vecs[i].ovf));
            release_op($sformatf("vec%0d", i));
        end

        // Consumer stalls for 10 cycles; a request presented meanwhile must be ignored.
        run_op(128'h0000_0001_0000_0002_0000_0003_0000_0004, 128'd9, 1'b1, 1'b0, lat);
        held_c  = out_c;
        held_co = out_co;
        chk("stall_c_first", held_c, 128'h0000_0001_0000_0002_0000_0003_0000_000E);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = {128{1'b1}}; in_b = {128{1'b1}};
            chk("stall_valid", 128'(out_valid), 128'd1);
            chk("stall_c", out_c, held_c);
            chk("stall_co", 128'(out_co), 128'(held_co));
            chk("stall_in_ready", 128'(in_ready), 128'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_op("stall");
        @(negedge clk);
        chk("stall_no_ghost", 128'(out_valid), 128'd0);

        // Reset in the middle of RUN at idx=2
        @(negedge clk);
        in_a = {128{1'b1}}; in_b = {128{1'b1}}; in_ci = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_out_c", out_c, 128'd0);
        chk("abort_out_co", 128'(out_co), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_still_idle", 128'(out_valid), 128'd0);
        run_op(128'd3, 128'd4, 1'b0, 1'b0, lat);
        chk("abort_next_latency", 128'(lat), 128'd5);
        chk("abort_next_c", out_c, 128'd7);
        chk("abort_next_co", 128'(out_co), 128'd0);
        chk("abort_next_ovf", 128'(out_ovf), 128'd0);
        release_op("abort_next");

        // Single-word instance: latency and co
        @(negedge clk);
        in_a1 = 8'hFF; in_b1 = 8'h01; in_ci1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b0;
        @(posedge clk);
        lat = 1;
        #1 in_valid1 = 1'b0;
        while (!out_valid1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w1_latency", 128'(lat), 128'd2);
        chk("w1_c", 128'(out_c1), 128'd0);
        chk("w1_co", 128'(out_co1), 128'd1);
        chk("w1_ovf", 128'(out_ovf1), 128'd0);
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1 out_ready1 = 1'b0;
        chk("w1_in_ready_after", 128'(in_ready1), 128'd1);

        // Back-to-back requests with the consumer always ready
        @(negedge clk);
        in_a1 = 8'h10; in_b1 = 8'h20; in_valid1 = 1'b1; out_ready1 = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (in_ready1) acc.push_back(cyc);
            if (out_valid1) chk("b2b_c", 128'(out_c1), 128'h30);
            @(negedge clk);
        end
        in_valid1 = 1'b0;
        if (acc.size() < 3) begin
            chk("b2b_accept_count", 128'(acc.size()), 128'd3);
        end else begin
            chk("b2b_first_accept", 128'(acc[0]), 128'd0);
            chk("b2b_interval_1", 128'(acc[1] - acc[0]), 128'd3);
            chk("b2b_interval_2", 128'(acc[2] - acc[1]), 128'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
